// File: rtl/fft_peak_detect.sv
// Streaming FFT peak finder: magnitude-squared argmax over bins < fftpts/2.
// Ports: Avalon-ST-like spectrum input, peak_* result strobe. Macro: PEAK_DC_SKIP_EN.
module fft_peak_detect #(
  parameter int MAX_PTS = 4096,
  parameter int SQ_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_error,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [31:0]          in_real,
  input  logic [31:0]          in_imag,
  input  logic [12:0]          fftpts,
  output logic                 peak_valid,
  output logic [12:0]          peak_bin,
  output logic [2*SQ_BITS:0]   peak_mag,
  output logic [1:0]           peak_error
);

  localparam int PW = 2 * SQ_BITS;
  localparam int MW = 2 * SQ_BITS + 1;
  localparam logic [12:0] MAXP = 13'(MAX_PTS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        fl_q, fl_d;
  logic        ready_q, ready_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] pts_q, pts_d;

  logic        acc, take, cand;
  logic [12:0] pts_in, pts_cur, idx;

  logic signed [SQ_BITS-1:0] a, b;
  logic signed [PW-1:0]      aa, bb;

  logic          s1_vld_q, s1_sop_q, s1_eop_q;
  logic          s1_cand_q, s1_err_q, s1_len_q;
  logic [12:0]   s1_bin_q;
  logic [PW-1:0] s1_aa_q, s1_bb_q;

  logic [MW-1:0] sum, base_mag, max_q, max_d;
  logic [12:0]   base_bin, mbin_q, mbin_d;
  logic          base_err, ferr_q, ferr_d;
  logic          done_q;
  logic [1:0]    rerr_q;

  logic          pv_q;
  logic [12:0]   pbin_q;
  logic [MW-1:0] pmag_q;
  logic [1:0]    perr_q;

  assign acc    = in_valid & ready_q;
  assign pts_in = (fftpts == 13'd0 || fftpts > MAXP) ? MAXP : fftpts;
  assign pts_cur = in_sop ? pts_in : pts_q;
  assign idx    = in_sop ? 13'd0 :
                  (cnt_q == 13'h1fff) ? cnt_q : cnt_q + 13'd1;
  assign take   = acc & (in_sop | (state_q == FRAME));

`ifdef PEAK_DC_SKIP_EN
  assign cand = (idx < (pts_cur >> 1)) && (idx != 13'd0);
`else
  assign cand = (idx < (pts_cur >> 1));
`endif

  assign a  = in_real[31 -: SQ_BITS];
  assign b  = in_imag[31 -: SQ_BITS];
  assign aa = a * a;
  assign bb = b * b;

  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    cnt_d   = cnt_q;
    pts_d   = pts_q;
    case (state_q)
      IDLE: begin
        if (acc && in_sop) begin
          cnt_d   = 13'd0;
          pts_d   = pts_in;
          fl_d    = 1'b0;
          state_d = in_eop ? FLUSH : FRAME;
        end
      end
      FRAME: begin
        if (acc) begin
          cnt_d = idx;
          if (in_sop) pts_d = pts_in;
          if (in_eop) begin
            fl_d    = 1'b0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fl_q) state_d = IDLE;
        else      fl_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != FLUSH);
  end

  // A sop beat restarts the running maximum, so aborted frames vanish.
  always_comb begin
    sum      = {1'b0, s1_aa_q} + {1'b0, s1_bb_q};
    base_mag = s1_sop_q ? '0 : max_q;
    base_bin = s1_sop_q ? 13'd0 : mbin_q;
    base_err = s1_sop_q ? 1'b0 : ferr_q;
    max_d    = max_q;
    mbin_d   = mbin_q;
    ferr_d   = ferr_q;
    if (s1_vld_q) begin
      max_d  = base_mag;
      mbin_d = base_bin;
      ferr_d = base_err | s1_err_q;
      if (s1_cand_q && sum > base_mag) begin
        max_d  = sum;
        mbin_d = s1_bin_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      fl_q      <= 1'b0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      pts_q     <= MAXP;
      s1_vld_q  <= 1'b0;
      s1_sop_q  <= 1'b0;
      s1_eop_q  <= 1'b0;
      s1_cand_q <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_len_q  <= 1'b0;
      s1_bin_q  <= '0;
      s1_aa_q   <= '0;
      s1_bb_q   <= '0;
      max_q     <= '0;
      mbin_q    <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      rerr_q    <= '0;
      pv_q      <= 1'b0;
      pbin_q    <= '0;
      pmag_q    <= '0;
      perr_q    <= '0;
    end else begin
      state_q   <= state_d;
      fl_q      <= fl_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      pts_q     <= pts_d;
      s1_vld_q  <= take;
      s1_sop_q  <= in_sop;
      s1_eop_q  <= in_eop;
      s1_cand_q <= cand;
      s1_err_q  <= |in_error;
      s1_len_q  <= in_eop && (idx != pts_cur - 13'd1);
      s1_bin_q  <= idx;
      s1_aa_q   <= aa;
      s1_bb_q   <= bb;
      max_q     <= max_d;
      mbin_q    <= mbin_d;
      ferr_q    <= ferr_d;
      done_q    <= s1_vld_q & s1_eop_q;
      if (s1_vld_q && s1_eop_q) rerr_q <= {s1_len_q, ferr_d};
      pv_q      <= done_q;
      if (done_q) begin
        pbin_q <= mbin_q;
        pmag_q <= max_q;
        perr_q <= rerr_q;
      end
    end
  end

  assign in_ready   = ready_q;
  assign peak_valid = pv_q;
  assign peak_bin   = pbin_q;
  assign peak_mag   = pmag_q;
  assign peak_error = perr_q;

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter MAX_PTS, default 4096, the largest supported frame length in points.
REQ-002 SHALL have parameter SQ_BITS, default 16, the number of MSBs of each component that are squared.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, the spectrum beat valid from the FFT source side.
REQ-006 SHALL have port in_ready, output, 1, the backpressure signal to the FFT source_ready.
REQ-007 SHALL have port in_error, input, 2, the beat error flags.
REQ-008 SHALL have ports in_sop and in_eop, input, 1 each, the packet delimiters.
REQ-009 SHALL have ports in_real and in_imag, input, 32 each, the signed two's-complement bin components.
REQ-010 SHALL have port fftpts, input, 13, the frame length in points; it is sampled on the accepted sop beat.
REQ-011 SHALL have port peak_valid, output, 1, a one-cycle result strobe.
REQ-012 SHALL have port peak_bin, output, 13, the index of the maximum bin.
REQ-013 SHALL have port peak_mag, output, 2*SQ_BITS+1, the magnitude squared of that bin.
REQ-014 SHALL have port peak_error, output, 2, the frame status: bit0 = in_error seen, bit1 = length mismatch.

Function
REQ-015 A beat SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-016 The FSM SHALL have three states: IDLE, FRAME and FLUSH.
REQ-017 In IDLE: in_ready=1; accepted beats without sop are discarded; an accepted sop beat is bin 0, and the state goes to FRAME (or FLUSH if eop is also set on that beat).
REQ-018 In FRAME: in_ready=1; each accepted beat increments the bin counter, which saturates at 8191.
REQ-019 In FRAME, an accepted beat with sop SHALL abort the current frame silently and restart at bin 0 with that beat.
REQ-020 In FRAME, an accepted eop beat SHALL go to FLUSH.
REQ-021 In FLUSH: in_ready=0 for exactly 2 cycles while the pipeline drains; the state then returns to IDLE.
REQ-022 Magnitude: a = in_real[31:32-SQ_BITS] and b = in_imag[31:32-SQ_BITS], both signed; stage 1 registers a*a and b*b; stage 2 forms their unsigned sum (2*SQ_BITS+1 bits, no overflow) and compares it.
REQ-023 Search range: only bins with index < fftpts/2 are candidates; other bins are consumed but ignored.
REQ-024 A candidate SHALL replace the held maximum only if it is strictly greater, so on ties the lowest bin wins.
REQ-025 The held maximum SHALL initialise to bin 0 with mag 0 at each sop.
REQ-026 peak_valid SHALL be 1 for exactly one cycle, 3 cycles after the eop-accept cycle T (i.e. at T+3); peak_bin, peak_mag and peak_error are valid in that cycle and held until the next strobe.
REQ-027 peak_error[0] SHALL be set if any accepted beat of the frame had in_error != 0.
REQ-028 peak_error[1] SHALL be set if the eop beat index != fftpts-1.
REQ-029 fftpts values of 0 or greater than MAX_PTS SHALL be treated as MAX_PTS.

Reset
REQ-030 When reset_n=0, the following SHALL hold asynchronously: state=IDLE, in_ready=0, peak_valid=0, peak_bin=0, peak_mag=0, peak_error=0, bin counter=0, and pipeline valid bits cleared.
REQ-031 in_ready SHALL rise in the first clock cycle after reset_n deasserts.
REQ-032 When reset asserts mid-frame, the partial frame SHALL be discarded and no peak_valid is issued for it.

Configuration
REQ-033 The macro PEAK_DC_SKIP_EN SHALL control DC exclusion: when defined, bin 0 is never a candidate, and a frame whose only nonzero candidate is bin 0 reports peak_bin=0 with peak_mag=0; when undefined, bin 0 is a normal candidate.

Verification
REQ-034 Scenario 1: with fftpts=16, stream 16 beats with sop/eop and bin 5 = (0x40000000, 0), all other bins 0 -> one peak_valid at T+3 with peak_bin=5, peak_mag=0x10000000, peak_error=0.
REQ-035 Scenario 2: with fftpts=16, set bins 3 and 6 to equal magnitude and bin 12 larger -> peak_bin=3, because bin 12 is out of range and the tie goes to the lower bin.
REQ-036 Scenario 3: with fftpts=16, send eop on beat 9 -> peak_error=2'b10, and in_ready is 0 for 2 cycles after eop.
REQ-037 Scenario 4: send sop at beat 4 of a frame, then a clean 16-beat frame -> exactly one peak_valid, for the second frame.
REQ-038 Scenario 5: with in_error=1 on beat 2 only -> peak_error[0]=1; also assert reset_n low mid-frame -> all outputs 0 and no strobe.
REQ-039 Scenario 6: with bin 0 = 0x7FFF0000 real and bin 2 small -> peak_bin=2 when PEAK_DC_SKIP_EN is defined, and peak_bin=0 when it is undefined.
